slave_protocol_controller: RTL and testbench
============================================

# slave_protocol_controller

Byte-level I2C slave controller that sequences a slave port: it synchronises SCL/SDA, detects START/STOP, matches the 7-bit address, shifts data in/out, and drives ACK and optional clock stretching. It sits between the open-drain pad cells and the slave's register/host logic. It runs on a system clock that oversamples the bus.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address this slave answers to.
- slave_clock  in  1  system clock; must be ≥ 8× SCL frequency.
- slave_rst  in  1  reset, asynchronous, active-low.
- slave_scl_in  in  1  raw SCL pad input.
- slave_sda_in  in  1  raw SDA pad input.
- slave_sda_oe  out  1  1 = pull SDA low.
- slave_scl_oe  out  1  1 = hold SCL low (stretch).
- rx_data  out  8  last received data byte.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  8  byte to transmit on reads.
- tx_valid  in  1  tx_data is available.
- tx_ack  out  1  one-cycle pulse; tx_data consumed.
- busy  out  1  slave is addressed (ADDR_ACK through end of transfer).
- rw  out  1  latched R/W bit of the current transfer.
- start_pulse  out  1  one-cycle pulse on START or repeated START.
- stop_pulse  out  1  one-cycle pulse on STOP.

## Operation
- Sync: two flops per line (reset to 1), plus one history flop. Derived per cycle: scl_rise, scl_fall, START (SDA 1→0 while SCL high both samples), STOP (SDA 0→1 while SCL high).
- Precedence: STOP > START > SCL edges. STOP in any state → IDLE. START in any state → ADDR. Both clear bit_cnt, release sda_oe/scl_oe, and pulse the respective output.
- States:
  - IDLE: all drives released.
  - ADDR: shift SDA on each scl_rise (MSB first), bit_cnt 0..7. After the 8th rise, latch rw = bit0. If shreg[7:1]==SLAVE_ADDR → ADDR_ACK on the next scl_fall with sda_oe=1; else → IGNORE.
  - ADDR_ACK: busy=1; hold sda_oe through the ack clock. On the next scl_fall, release and go to RX (rw=0) or TX_LOAD (rw=1).
  - RX: shift 8 bits on scl_rise. Cycle after the 8th rise: rx_data←shreg, rx_valid pulse. Next scl_fall → RX_ACK, sda_oe=1.
  - RX_ACK: release on the next scl_fall → RX.
  - TX_LOAD (same cycle as entering scl_fall):
    - If tx_valid: load shreg←tx_data, pulse tx_ack, drive MSB (sda_oe = ~bit) → TX.
  - TX: each scl_fall drives the next bit. The 8th scl_fall releases SDA → TX_MACK.
  - TX_MACK: sample SDA on scl_rise. 0 (ACK): next scl_fall → TX_LOAD. 1 (NACK) → IGNORE.
  - IGNORE: drives released; wait for START/STOP.
- busy clears on IDLE or IGNORE entry.
- rw holds its value until the next address phase.
- shreg and bit_cnt are 8- and 4-bit; bit_cnt never wraps (cleared on each byte boundary).

## Timing
- Reset values: sda_oe=0, scl_oe=0, rx_data=8'h00, rx_valid=0, tx_ack=0, busy=0, rw=0, start_pulse=0, stop_pulse=0; FSM=IDLE; sync flops=1. Reset is asynchronous: drives release immediately on slave_rst low, mid-transfer included.
- Pin edge → scl_rise/scl_fall/START/STOP asserted at the 3rd slave_clock edge.
- sda_oe/scl_oe are registered and change one cycle after the detected scl_fall, so SDA changes only while SCL is low.
- rx_valid: 1 cycle after the 8th data scl_rise detection, before ACK is driven.
- tx_ack coincides with the cycle shreg loads.

## Configuration
- SLAVE_CLK_STRETCH_EN defined:
  - In TX_LOAD with tx_valid=0, enter TX_WAIT and assert scl_oe. The cycle tx_valid is seen high, load, pulse tx_ack, drive MSB. scl_oe releases one cycle later.
  - TX_WAIT honours START/STOP.
- Undefined:
  - scl_oe is tied 0.
  - TX_LOAD with tx_valid=0 sends 8'hFF (SDA released), with no tx_ack.

## Test plan
- Write 0xA0, 0x3C, STOP → sda_oe high on both 9th clocks, rx_data=0x3C with one rx_valid pulse, rw=0, stop_pulse once, busy back to 0.
- Address byte 0xA2 (addr 0x51) → sda_oe never asserts, no rx_valid, busy stays 0, IDLE after STOP.
- Read 0xA1, tx_data=0xC5, tx_valid=1 → SDA bits 1,1,0,0,0,1,0,1. Master ACK → second tx_ack. Master NACK → SDA released, no further tx_ack.
- Repeated START after 4 data bits → start_pulse, sda_oe 0, new address 0xA0 ACKed normally.
- With SLAVE_CLK_STRETCH_EN, tx_valid low 50 cycles at TX_LOAD → scl_oe high ≥50 cycles, releasing 1 cycle after tx_valid rises. Without the macro → byte 0xFF on SDA, tx_ack absent.
- slave_rst low during ADDR_ACK → sda_oe drops without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/slave_protocol_controller_if.sv
// Bus bundle between the I2C slave controller, its pad cells and the host logic.
//   slave_scl_in / slave_sda_in : raw pad inputs (wired-AND line level)
//   slave_sda_oe / slave_scl_oe : 1 = pull the line low
//   rx_data / rx_valid          : received data byte and its one-cycle strobe
//   tx_data / tx_valid / tx_ack : byte offered for reads, consumed strobe
//   busy / rw                   : slave addressed, latched R/W bit
//   start_pulse / stop_pulse    : one-cycle bus condition strobes
// Modport slave is the controller's view; modport master is the pad/host side.
interface slave_protocol_controller_if;
    logic       slave_scl_in;
    logic       slave_sda_in;
    logic       slave_sda_oe;
    logic       slave_scl_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic       busy;
    logic       rw;
    logic       start_pulse;
    logic       stop_pulse;

    modport slave (
        input  slave_scl_in, slave_sda_in, tx_data, tx_valid,
        output slave_sda_oe, slave_scl_oe, rx_data, rx_valid, tx_ack,
               busy, rw, start_pulse, stop_pulse
    );

    modport master (
        output slave_scl_in, slave_sda_in, tx_data, tx_valid,
        input  slave_sda_oe, slave_scl_oe, rx_data, rx_valid, tx_ack,
               busy, rw, start_pulse, stop_pulse
    );
endinterface

// File: rtl/slave_protocol_controller.sv
// Byte-level I2C slave controller: synchronises SCL/SDA, detects START/STOP,
// matches a 7-bit address, shifts data in/out, drives ACK and (optionally)
// stretches SCL while waiting for transmit data.
// Ports:
//   slave_clock : system clock, at least 8x the SCL frequency
//   slave_rst   : asynchronous active-low reset
//   bus         : slave_protocol_controller_if.slave (pads + host handshake)
// Parameter SLAVE_ADDR : 7-bit bus address answered by this slave.
// Build option: define SLAVE_CLK_STRETCH_EN to hold SCL low while no transmit
// byte is available; otherwise an empty transmit slot sends 8'hFF.
module slave_protocol_controller #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic                              slave_clock,
    input  logic                              slave_rst,
    slave_protocol_controller_if.slave        bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W);
    localparam logic [CNT_W-1:0] CNT_MSB7 = CNT_W'(BYTE_W - 1);
    // Marks a received byte as already delivered while waiting for the ACK fall.
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(BYTE_W + 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_MACK,
        TX_WAIT,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sda_oe_q, sda_oe_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ack_q, tx_ack_d;
    logic              busy_q, busy_d;
    logic              rw_q, rw_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;
    logic              tx_load;
`ifdef SLAVE_CLK_STRETCH_EN
    logic              scl_oe_q, scl_oe_d;
`endif

    // Two-flop synchronisers plus one history flop per line.
    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    always_ff @(posedge slave_clock or negedge slave_rst) begin
        if (!slave_rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= bus.slave_scl_in;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= bus.slave_sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    // State and output registers.
    always_ff @(posedge slave_clock or negedge slave_rst) begin
        if (!slave_rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
`ifdef SLAVE_CLK_STRETCH_EN
            scl_oe_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
`ifdef SLAVE_CLK_STRETCH_EN
            scl_oe_q   <= scl_oe_d;
`endif
        end
    end

    // Next-state and next-output logic; STOP beats START beats SCL edges.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        tx_load    = 1'b0;
`ifdef SLAVE_CLK_STRETCH_EN
        scl_oe_d   = scl_oe_q;
`endif

        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
`ifdef SLAVE_CLK_STRETCH_EN
            scl_oe_d  = 1'b0;
`endif
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            start_d   = 1'b1;
`ifdef SLAVE_CLK_STRETCH_EN
            scl_oe_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
`ifdef SLAVE_CLK_STRETCH_EN
                    scl_oe_d = 1'b0;
`endif
                end
                ADDR: begin
                    if (scl_rise && bit_cnt_q < CNT_LAST) begin
                        shreg_d   = {shreg_q[BYTE_W-2:0], sda_s2};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_MSB7) begin
                            rw_d = sda_s2;
                        end
                    end else if (scl_fall && bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        if (shreg_q[BYTE_W-1:1] == SLAVE_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                            busy_d   = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    busy_d = 1'b1;
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        if (rw_q) begin
                            tx_load = 1'b1;
                        end else begin
                            state_d = RX;
                        end
                    end
                end
                RX: begin
                    if (scl_rise && bit_cnt_q < CNT_LAST) begin
                        shreg_d   = {shreg_q[BYTE_W-2:0], sda_s2};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    // Byte completes the cycle after the 8th rise, before ACK.
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = CNT_DONE;
                    end
                    if (scl_fall && bit_cnt_q >= CNT_LAST) begin
                        state_d   = RX_ACK;
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_d   = RX;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_LAST) begin
                            state_d   = TX_MACK;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            sda_oe_d  = ~shreg_q[BYTE_W-2];
                            shreg_d   = {shreg_q[BYTE_W-2:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                TX_MACK: begin
                    // bit_cnt=1 records that the master acknowledged.
                    if (scl_rise) begin
                        if (sda_s2) begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end else begin
                            bit_cnt_d = CNT_W'(1);
                        end
                    end else if (scl_fall && bit_cnt_q == CNT_W'(1)) begin
                        bit_cnt_d = '0;
                        tx_load   = 1'b1;
                    end
                end
`ifdef SLAVE_CLK_STRETCH_EN
                TX_WAIT: begin
                    if (bus.tx_valid) begin
                        tx_load = 1'b1;
                    end
                end
`endif
                IGNORE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
`ifdef SLAVE_CLK_STRETCH_EN
                    scl_oe_d = 1'b0;
`endif
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase

            // Transmit slot opens on the SCL fall itself so the MSB is on SDA
            // one cycle later, well inside the low phase.
            if (tx_load) begin
                if (bus.tx_valid) begin
                    shreg_d   = bus.tx_data;
                    tx_ack_d  = 1'b1;
                    sda_oe_d  = ~bus.tx_data[BYTE_W-1];
                    bit_cnt_d = CNT_W'(1);
                    state_d   = TX;
`ifdef SLAVE_CLK_STRETCH_EN
                    scl_oe_d  = 1'b0;
`endif
                end else begin
`ifdef SLAVE_CLK_STRETCH_EN
                    state_d   = TX_WAIT;
                    scl_oe_d  = 1'b1;
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
`else
                    shreg_d   = '1;
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = TX;
`endif
                end
            end
        end
    end

    assign bus.slave_sda_oe = sda_oe_q;
`ifdef SLAVE_CLK_STRETCH_EN
    assign bus.slave_scl_oe = scl_oe_q;
`else
    assign bus.slave_scl_oe = 1'b0;
`endif
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ack      = tx_ack_q;
    assign bus.busy        = busy_q;
    assign bus.rw          = rw_q;
    assign bus.start_pulse = start_q;
    assign bus.stop_pulse  = stop_q;
endmodule

// File: tb/tb_slave_protocol_controller.sv
// Self-checking bench for slave_protocol_controller: an open-drain I2C master
// model with scoreboard queues for received and transmitted bytes.
`timescale 1ns/1ps
module tb_slave_protocol_controller;
    localparam int Q = 5;  // quarter SCL period in system clocks

    logic clk = 1'b0;
    logic rst;
    logic m_scl;
    logic m_sda;

    int tests = 0;
    int fails = 0;

    int rx_cnt = 0, tx_ack_cnt = 0, start_cnt = 0, stop_cnt = 0;
    int sda_oe_cyc = 0, busy_cyc = 0, scl_oe_cyc = 0;
    logic [7:0] rx_log [0:15];
    logic [7:0] rx_exp [$];
    logic [7:0] tx_exp [$];

    slave_protocol_controller_if bus();

    slave_protocol_controller dut (
        .slave_clock (clk),
        .slave_rst   (rst),
        .bus         (bus)
    );

    assign bus.slave_scl_in = m_scl & ~bus.slave_scl_oe;
    assign bus.slave_sda_in = m_sda & ~bus.slave_sda_oe;

    always #5 clk = ~clk;

    // Output monitor: counts pulses and drive cycles, logs received bytes.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_valid) begin
                if (rx_cnt < 16) rx_log[4'(rx_cnt)] <= bus.rx_data;
                rx_cnt <= rx_cnt + 1;
            end
            if (bus.tx_ack)       tx_ack_cnt <= tx_ack_cnt + 1;
            if (bus.start_pulse)  start_cnt  <= start_cnt + 1;
            if (bus.stop_pulse)   stop_cnt   <= stop_cnt + 1;
            if (bus.slave_sda_oe) sda_oe_cyc <= sda_oe_cyc + 1;
            if (bus.busy)         busy_cyc   <= busy_cyc + 1;
            if (bus.slave_scl_oe) scl_oe_cyc <= scl_oe_cyc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        m_scl = 1'b1;
        for (int i = 0; i < 400 && bus.slave_scl_in !== 1'b1; i++) @(negedge clk);
        if (bus.slave_scl_in !== 1'b1) begin
            tests++; fails++;
            $display("FAIL scl_timeout: scl line %b, required 1", bus.slave_scl_in);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_cyc(Q);
        scl_high();   wait_cyc(Q);
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_cyc(Q);
        scl_high();   wait_cyc(Q);
        m_sda = 1'b1; wait_cyc(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_cyc(Q);
        scl_high(); wait_cyc(2 * Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_cyc(Q);
        scl_high(); wait_cyc(Q);
        b = bus.slave_sda_in; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        wait_cyc(3);
        tests++; if (bus.slave_sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b, required 0", bus.slave_sda_oe); end
        tests++; if (bus.slave_scl_oe !== 1'b0) begin fails++; $display("FAIL reset_scl_oe: got %b, required 0", bus.slave_scl_oe); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h, required 00", bus.rx_data); end
        tests++; if ({bus.rx_valid, bus.tx_ack, bus.busy, bus.rw, bus.start_pulse, bus.stop_pulse} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b, required 000000",
                {bus.rx_valid, bus.tx_ack, bus.busy, bus.rw, bus.start_pulse, bus.stop_pulse});
        end
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_write();
        int rx0, sp0;
        logic ack;
        logic [7:0] e;
        rx0 = rx_cnt; sp0 = stop_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_addr_ack: got %b, required 0", ack); end
        rx_exp.push_back(8'h3C);
        write_byte(8'h3C, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_data_ack: got %b, required 0", ack); end
        tests++; if (bus.rw !== 1'b0) begin fails++; $display("FAIL wr_rw: got %b, required 0", bus.rw); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL wr_busy: got %b, required 1", bus.busy); end
        i2c_stop();
        wait_cyc(4);
        tests++; if (stop_cnt - sp0 !== 1) begin fails++; $display("FAIL wr_stop_pulses: got %0d, required 1", stop_cnt - sp0); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL wr_busy_end: got %b, required 0", bus.busy); end
        tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL wr_rx_pulses: got %0d, required 1", rx_cnt - rx0); end
        for (int k = rx0; k < rx_cnt; k++) begin
            tests++;
            if (rx_exp.size() == 0) begin
                fails++; $display("FAIL wr_rx_extra: got %h, required none", rx_log[4'(k)]);
            end else begin
                e = rx_exp.pop_front();
                if (rx_log[4'(k)] !== e) begin fails++; $display("FAIL wr_rx_data: got %h, required %h", rx_log[4'(k)], e); end
            end
        end
        tests++; if (rx_exp.size() != 0) begin fails++; $display("FAIL wr_rx_missing: got %0d pending, required 0", rx_exp.size()); rx_exp.delete(); end
    endtask

    task automatic test_addr_mismatch();
        int rx0, oe0, bz0;
        logic ack;
        rx0 = rx_cnt; oe0 = sda_oe_cyc; bz0 = busy_cyc;
        i2c_start();
        write_byte(8'hA2, ack);
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL mm_addr_nack: got %b, required 1", ack); end
        write_byte(8'h55, ack);
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL mm_data_nack: got %b, required 1", ack); end
        i2c_stop();
        wait_cyc(4);
        tests++; if (sda_oe_cyc - oe0 !== 0) begin fails++; $display("FAIL mm_sda_oe: got %0d cycles, required 0", sda_oe_cyc - oe0); end
        tests++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL mm_rx_valid: got %0d, required 0", rx_cnt - rx0); end
        tests++; if (busy_cyc - bz0 !== 0) begin fails++; $display("FAIL mm_busy: got %0d cycles, required 0", busy_cyc - bz0); end
    endtask

    task automatic test_read();
        int ta0;
        logic ack;
        logic [7:0] d, e;
        ta0 = tx_ack_cnt;
        bus.tx_data = 8'hC5; bus.tx_valid = 1'b1; tx_exp.push_back(8'hC5);
        i2c_start();
        write_byte(8'hA1, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_addr_ack: got %b, required 0", ack); end
        tests++; if (bus.rw !== 1'b1) begin fails++; $display("FAIL rd_rw: got %b, required 1", bus.rw); end
        for (int n = 0; n < 2; n++) begin
            read_byte(d);
            e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'hxx;
            tests++; if (d !== e) begin fails++; $display("FAIL rd_byte%0d: got %h, required %h", n, d, e); end
            tests++; if (tx_ack_cnt - ta0 !== n + 1) begin fails++; $display("FAIL rd_tx_ack%0d: got %0d, required %0d", n, tx_ack_cnt - ta0, n + 1); end
            if (n == 0) begin
                bus.tx_data = 8'h3A; tx_exp.push_back(8'h3A);
                write_bit(1'b0);
            end else begin
                write_bit(1'b1);
            end
        end
        wait_cyc(20);
        tests++; if (tx_ack_cnt - ta0 !== 2) begin fails++; $display("FAIL rd_no_more_ack: got %0d, required 2", tx_ack_cnt - ta0); end
        tests++; if (bus.slave_sda_oe !== 1'b0) begin fails++; $display("FAIL rd_nack_release: got %b, required 0", bus.slave_sda_oe); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rd_nack_busy: got %b, required 0", bus.busy); end
        i2c_stop();
        bus.tx_valid = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_repeated_start();
        int rx0, st0;
        logic ack;
        logic [7:0] e;
        rx0 = rx_cnt; st0 = start_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rs_first_ack: got %b, required 0", ack); end
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_start();
        tests++; if (start_cnt - st0 !== 2) begin fails++; $display("FAIL rs_start_pulses: got %0d, required 2", start_cnt - st0); end
        tests++; if (bus.slave_sda_oe !== 1'b0) begin fails++; $display("FAIL rs_sda_oe: got %b, required 0", bus.slave_sda_oe); end
        write_byte(8'hA0, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rs_addr_ack: got %b, required 0", ack); end
        rx_exp.push_back(8'h96);
        write_byte(8'h96, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rs_data_ack: got %b, required 0", ack); end
        i2c_stop();
        wait_cyc(4);
        tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL rs_rx_pulses: got %0d, required 1", rx_cnt - rx0); end
        for (int k = rx0; k < rx_cnt; k++) begin
            tests++;
            if (rx_exp.size() == 0) begin
                fails++; $display("FAIL rs_rx_extra: got %h, required none", rx_log[4'(k)]);
            end else begin
                e = rx_exp.pop_front();
                if (rx_log[4'(k)] !== e) begin fails++; $display("FAIL rs_rx_data: got %h, required %h", rx_log[4'(k)], e); end
            end
        end
        if (rx_exp.size() != 0) rx_exp.delete();
    endtask

    task automatic test_tx_empty();
        int ta0, sc0;
        logic ack;
        logic [7:0] d, e;
        ta0 = tx_ack_cnt; sc0 = scl_oe_cyc;
        bus.tx_valid = 1'b0;
`ifdef SLAVE_CLK_STRETCH_EN
        begin
            logic held;
            i2c_start();
            write_byte(8'hA1, ack);
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL st_addr_ack: got %b, required 0", ack); end
            for (int i = 0; i < 20 && bus.slave_scl_oe !== 1'b1; i++) wait_cyc(1);
            tests++; if (bus.slave_scl_oe !== 1'b1) begin fails++; $display("FAIL st_assert: got %b, required 1", bus.slave_scl_oe); end
            held = 1'b1;
            for (int i = 0; i < 50; i++) begin
                wait_cyc(1);
                if (bus.slave_scl_oe !== 1'b1) held = 1'b0;
            end
            tests++; if (held !== 1'b1) begin fails++; $display("FAIL st_hold: got %b, required 1", held); end
            bus.tx_data = 8'h5A; bus.tx_valid = 1'b1; tx_exp.push_back(8'h5A);
            wait_cyc(1);
            tests++; if (bus.slave_scl_oe !== 1'b0) begin fails++; $display("FAIL st_release: got %b, required 0", bus.slave_scl_oe); end
            tests++; if (bus.tx_ack !== 1'b1) begin fails++; $display("FAIL st_tx_ack: got %b, required 1", bus.tx_ack); end
            tests++; if (scl_oe_cyc - sc0 < 50) begin fails++; $display("FAIL st_cycles: got %0d, required >=50", scl_oe_cyc - sc0); end
            bus.tx_valid = 1'b0;
            read_byte(d);
            e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'hxx;
            tests++; if (d !== e) begin fails++; $display("FAIL st_byte: got %h, required %h", d, e); end
            write_bit(1'b1);
            i2c_stop();
        end
`else
        tx_exp.push_back(8'hFF);
        i2c_start();
        write_byte(8'hA1, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL ns_addr_ack: got %b, required 0", ack); end
        read_byte(d);
        e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'hxx;
        tests++; if (d !== e) begin fails++; $display("FAIL ns_byte: got %h, required %h", d, e); end
        write_bit(1'b1);
        i2c_stop();
        wait_cyc(4);
        tests++; if (tx_ack_cnt - ta0 !== 0) begin fails++; $display("FAIL ns_tx_ack: got %0d, required 0", tx_ack_cnt - ta0); end
        tests++; if (scl_oe_cyc - sc0 !== 0) begin fails++; $display("FAIL ns_scl_oe: got %0d cycles, required 0", scl_oe_cyc - sc0); end
`endif
        wait_cyc(4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        a = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        tests++; if (bus.slave_sda_oe !== 1'b1) begin fails++; $display("FAIL rm_ack_driven: got %b, required 1", bus.slave_sda_oe); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rm_busy_before: got %b, required 1", bus.busy); end
        #2 rst = 1'b0;
        #1;
        tests++; if (bus.slave_sda_oe !== 1'b0) begin fails++; $display("FAIL rm_async_release: got %b, required 0", bus.slave_sda_oe); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL rm_rx_data: got %h, required 00", bus.rx_data); end
        tests++; if ({bus.slave_scl_oe, bus.rx_valid, bus.tx_ack, bus.busy, bus.rw, bus.start_pulse, bus.stop_pulse} !== 7'b0) begin
            fails++; $display("FAIL rm_flags: got %b, required 0000000",
                {bus.slave_scl_oe, bus.rx_valid, bus.tx_ack, bus.busy, bus.rw, bus.start_pulse, bus.stop_pulse});
        end
        m_scl = 1'b1; m_sda = 1'b1;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(5);
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_repeated_start();
        test_tx_empty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
